// File: rtl/cnn1d_pkg.sv
// rtl/cnn1d_pkg.sv - shared constants and types for the ADC front-end of the cnn1d datapath
package cnn1d_pkg;

    localparam int ADC_WIDTH  = 16;
    localparam int ADC_NUM_CH = 4;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_rr_arbiter_pick.sv
// rtl/adc_rr_arbiter_pick.sv - combinational rotating priority encoder
module rr_priority_pick
    import cnn1d_pkg::*;
#(
    parameter int NUM_CH   = ADC_NUM_CH,
    parameter int CH_WIDTH = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0]   req,
    input  logic [CH_WIDTH-1:0] ptr,
    output logic                found,
    output logic [CH_WIDTH-1:0] idx
);

    logic [CH_WIDTH:0]   sum;
    logic [CH_WIDTH-1:0] cand;

    // Walk from the farthest offset down so the closest requester to ptr wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (CH_WIDTH + 1)'(i);
            if (sum >= (CH_WIDTH + 1)'(NUM_CH)) begin
                sum = sum - (CH_WIDTH + 1)'(NUM_CH);
            end
            cand = sum[CH_WIDTH-1:0];
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/adc_rr_arbiter.sv
// rtl/adc_rr_arbiter.sv - round-robin burst arbiter feeding one adc2v pipeline from NUM_CH streams
module adc_rr_arbiter
    import cnn1d_pkg::*;
#(
    parameter int NUM_CH = ADC_NUM_CH,
    parameter int BURST  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              ch_valid_in,
    output logic [NUM_CH-1:0]              ch_ready_in,
    input  logic [NUM_CH*ADC_WIDTH-1:0]    ch_data_in,
    output logic                           adc_valid_out,
    input  logic                           adc_ready_out,
    output logic [ADC_WIDTH-1:0]           adc_data_out,
    output logic [ch_width(NUM_CH)-1:0]    adc_ch_out,
    output logic                           adc_last_out
);

    localparam int CH_WIDTH  = ch_width(NUM_CH);
    localparam int CNT_WIDTH = ch_width(BURST);

    arb_state_t            state;
    logic [CH_WIDTH-1:0]   rr_ptr;
    logic [CH_WIDTH-1:0]   grant;
    logic [CNT_WIDTH-1:0]  count;

    logic                  found;
    logic [CH_WIDTH-1:0]   pick;
    logic                  out_free;
    logic                  xfer;
    logic                  at_last;
    logic [CH_WIDTH-1:0]   next_ptr;
    logic [ADC_WIDTH-1:0]  sel_data;

    rr_priority_pick #(
        .NUM_CH   (NUM_CH),
        .CH_WIDTH (CH_WIDTH)
    ) u_pick (
        .req   (ch_valid_in),
        .ptr   (rr_ptr),
        .found (found),
        .idx   (pick)
    );

    assign out_free = ~adc_valid_out | adc_ready_out;
    assign xfer     = (state == ARB_GRANT) & ch_valid_in[grant] & out_free;
    assign at_last  = (count == CNT_WIDTH'(BURST - 1));
    assign next_ptr = (grant == CH_WIDTH'(NUM_CH - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        ch_ready_in = '0;
        if (state == ARB_GRANT) begin
            ch_ready_in[grant] = out_free;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant == CH_WIDTH'(k)) begin
                sel_data = ch_data_in[k*ADC_WIDTH +: ADC_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ARB_IDLE;
            rr_ptr        <= '0;
            grant         <= '0;
            count         <= '0;
            adc_valid_out <= 1'b0;
            adc_data_out  <= '0;
            adc_ch_out    <= '0;
            adc_last_out  <= 1'b0;
        end else begin
            // A same-cycle pop and transfer simply overwrites the register.
            if (xfer) begin
                adc_data_out  <= sel_data;
                adc_ch_out    <= grant;
                adc_last_out  <= at_last;
                adc_valid_out <= 1'b1;
            end else if (adc_ready_out) begin
                adc_valid_out <= 1'b0;
            end

            if (state == ARB_IDLE) begin
                if (found) begin
                    grant <= pick;
                    count <= '0;
                    state <= ARB_GRANT;
                end
            end else begin
                // Burst ends on the BURST-th sample or when the channel lets go.
                if (!ch_valid_in[grant] || (xfer && at_last)) begin
                    state  <= ARB_IDLE;
                    rr_ptr <= next_ptr;
                    count  <= '0;
                end else if (xfer) begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/adc_rr_arbiter.md
Name: adc_rr_arbiter

Overview:
- Round-robin arbiter that shares one adc2v conversion pipeline between NUM_CH independent ADC sample streams.
- Each granted channel may send a burst of up to BURST samples. Each forwarded sample is tagged with its channel index and an end-of-burst flag, so downstream CNN window logic can demultiplex the stream.
- Sits between the per-channel ADC capture front-ends and the adc2v input (adc_*_in side).

Parameters:
- NUM_CH, 4, number of requesting ADC channels (1..16).
- BURST, 8, maximum samples accepted per grant before the pointer rotates (>=1).
- CH_WIDTH, $clog2(NUM_CH) with a minimum of 1, width of the channel tag; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low (asserted at 0).
- ch_valid_in  input  NUM_CH  per-channel sample valid.
- ch_ready_in  output  NUM_CH  per-channel ready; at most one bit high.
- ch_data_in  input  NUM_CH*ADC_WIDTH  packed channel samples; channel k is at bits [k*ADC_WIDTH +: ADC_WIDTH].
- adc_valid_out  output  1  output sample valid, toward adc2v.
- adc_ready_out  input  1  downstream ready, from adc2v adc_ready_in.
- adc_data_out  output  ADC_WIDTH  forwarded sample.
- adc_ch_out  output  CH_WIDTH  channel index of adc_data_out.
- adc_last_out  output  1  high on the BURST-th sample of a grant.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, rr_ptr=0, grant=0, count=0.
  - adc_valid_out=0, adc_data_out=0, adc_ch_out=0, adc_last_out=0, ch_ready_in=0.
  - Any in-flight output sample is discarded.
- out_free = ~adc_valid_out | adc_ready_out.
- The output register loads only on an input transfer. It holds data, ch and last stable while adc_valid_out=1 and adc_ready_out=0.
- adc_valid_out clears when adc_ready_out=1 and no new transfer occurs that cycle.
- FSM state IDLE:
  - ch_ready_in=0.
  - Pick the first channel with ch_valid_in high, scanning from rr_ptr upward with wrap.
  - If one is found: grant<=pick, count<=0, go to GRANT. Otherwise stay in IDLE.
- FSM state GRANT:
  - ch_ready_in[grant]=out_free; all other bits are 0.
  - Transfer = ch_valid_in[grant] & ch_ready_in[grant].
  - On transfer: output register <= {ch_data_in[grant], grant, count==BURST-1}, adc_valid_out<=1, count<=count+1.
  - Transfer with count==BURST-1: go to IDLE, rr_ptr<=(grant+1) mod NUM_CH.
  - ch_valid_in[grant]=0 (early release): go to IDLE, rr_ptr<=(grant+1) mod NUM_CH. No retroactive last flag; the burst simply ends short.
  - ch_valid_in[grant]=1 but out_free=0: hold in GRANT, count unchanged.
- Latency and throughput:
  - IDLE to GRANT takes 1 cycle.
  - The first sample of a grant is accepted in the first GRANT cycle and appears at adc_valid_out the next cycle.
  - Sustained rate is 1 sample/cycle within a burst, with exactly one IDLE bubble between grants.
- Boundary conditions:
  - NUM_CH=1: rr_ptr stays 0.
  - BURST=1: every sample has last=1, and the pointer rotates after every sample.
  - Channels are served in rotating order. A channel that is never valid is skipped with no extra cycles.
  - Simultaneous transfer and downstream pop in the same cycle: new sample replaces old, valid stays 1.
  - rr_ptr wraps from NUM_CH-1 to 0.
  - count never exceeds BURST-1.

Decomposition:
- cnn1d_pkg:
  - Reuse ADC_WIDTH.
  - Add constant ADC_NUM_CH=4.
  - Add typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t.
- Sub-module rr_priority_pick: combinational rotating priority encoder.
  - Inputs: req[NUM_CH], ptr[CH_WIDTH].
  - Outputs: found, idx[CH_WIDTH].
  - Unit-testable standalone.

Test Plan:
- Reset: assert rst=0 mid-burst while adc_valid_out=1 → adc_valid_out=0 and ch_ready_in=0 immediately. After release with all channels valid, the first output has adc_ch_out=0.
- Full load: NUM_CH=4, BURST=8, all valid, adc_ready_out=1, channel k sends k*1000+n.
  - Tags run 0×8, 1×8, 2×8, 3×8, 0…
  - adc_last_out is high on every 8th sample.
  - 32 samples arrive in 36 cycles.
- Single requester: only ch2 valid → repeated 8-sample bursts tagged 2, one bubble between bursts, data in order with no gaps.
- Early release: ch1 granted, drops valid after 3 samples, ch2 valid → 3 ch1 samples with last=0, then the ch2 burst starts after one IDLE cycle.
- Backpressure: adc_ready_out randomised 50% over 2000 samples → per-channel scoreboard shows no loss, duplication or reordering. Output stays stable while stalled, and at most one ch_ready_in bit is high.
- Config NUM_CH=3, BURST=1, all valid → tags strictly 0,1,2,0… with last=1 on every sample.
